grid_frame_streamer: RTL

//  Parametrised AXI4-Stream video source that renders a cell-grid state map as an RGB frame.

---
 rtl/grid_stream_pkg.sv | 15 +
 rtl/rgb_packer_4to3.sv | 95 +++++++++
 rtl/grid_frame_streamer.sv | 97 +++++++++
 3 files changed

// File: rtl/grid_stream_pkg.sv
// Shared types and constants for the grid frame streamer and its pixel packer.
package grid_stream_pkg;

  localparam int         AXIS_W    = 32;
  localparam logic [3:0] TKEEP_ALL = 4'hF;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} pack_phase_t;

  function automatic int ceil_shift(input int n, input int s);
    return (n + (1 << s) - 1) >> s;
  endfunction

endpackage

// File: rtl/rgb_packer_4to3.sv
// Packs four 24-bit pixels into three 32-bit AXI4-Stream beats, lowest pixel in the lowest bits.
//  state | meaning
//  PH0   | waiting for p0; next pixel is stored whole, no beat
//  PH1   | p0 held; p1 completes beat {p1[7:0],p0}
//  PH2   | p1[23:8] held; p2 completes beat {p2[15:0],p1[23:8]}
//  PH3   | p2[23:16] held; p3 completes beat {p3,p2[23:16]}
module rgb_packer_4to3
  import grid_stream_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              en,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eol,
  input  rgb_t              in_rgb,
  output logic [AXIS_W-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  output logic              tuser
);

  pack_phase_t       phase, phase_n;
  rgb_t              res, res_n;
  logic              sof_q, sof_n;
  logic [AXIS_W-1:0] tdata_n;
  logic              tvalid_n, tlast_n, tuser_n;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase  <= PH0;
      res    <= '0;
      sof_q  <= 1'b0;
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tuser  <= 1'b0;
    end else begin
      phase  <= phase_n;
      res    <= res_n;
      sof_q  <= sof_n;
      tdata  <= tdata_n;
      tvalid <= tvalid_n;
      tlast  <= tlast_n;
      tuser  <= tuser_n;
    end
  end

  // Beat fields only move when en is high, which keeps a stalled beat stable.
  always_comb begin
    phase_n  = phase;
    res_n    = res;
    sof_n    = sof_q;
    tdata_n  = tdata;
    tvalid_n = tvalid;
    tlast_n  = tlast;
    tuser_n  = tuser;
    if (en) begin
      tvalid_n = 1'b0;
      if (in_valid) begin
        case (phase)
          PH0: begin
            res_n   = in_rgb;
            sof_n   = in_sof;
            phase_n = PH1;
          end
          PH1: begin
            tvalid_n = 1'b1;
            tdata_n  = {in_rgb[7:0], res};
            tuser_n  = sof_q;
            tlast_n  = 1'b0;
            res_n    = {8'h00, in_rgb[23:8]};
            phase_n  = PH2;
          end
          PH2: begin
            tvalid_n = 1'b1;
            tdata_n  = {in_rgb[15:0], res[15:0]};
            tuser_n  = 1'b0;
            tlast_n  = 1'b0;
            res_n    = {16'h0000, in_rgb[23:16]};
            phase_n  = PH3;
          end
          default: begin
            tvalid_n = 1'b1;
            tdata_n  = {in_rgb, res[7:0]};
            tuser_n  = 1'b0;
            tlast_n  = in_eol;
            phase_n  = PH0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/grid_frame_streamer.sv
// AXI4-Stream video source: scans the frame, reads cell states from a sync RAM,
// maps them through a palette with optional cell borders, and packs pixels into beats.
module grid_frame_streamer
  import grid_stream_pkg::*;
#(
  parameter int                             X_SIZE      = 640,
  parameter int                             Y_SIZE      = 480,
  parameter int                             CELL_W_LOG2 = 5,
  parameter int                             CELL_H_LOG2 = 5,
  parameter int                             STATE_BITS  = 2,
  parameter logic [24*(2**STATE_BITS)-1:0]  PALETTE     = {24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h000000},
  parameter logic [23:0]                    GRID_RGB    = 24'h404040,
  localparam int GRID_W = X_SIZE >> CELL_W_LOG2,
  localparam int GRID_H = ceil_shift(Y_SIZE, CELL_H_LOG2),
  localparam int AW     = (GRID_W * GRID_H > 1) ? $clog2(GRID_W * GRID_H) : 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  run,
  input  logic                  grid_en,
  output logic [AW-1:0]         state_addr,
  output logic                  state_rd_en,
  input  logic [STATE_BITS-1:0] state_data,
  output logic                  frame_done,
  output logic [AXIS_W-1:0]     out_stream_tdata,
  output logic [3:0]            out_stream_tkeep,
  output logic                  out_stream_tlast,
  input  logic                  out_stream_tready,
  output logic                  out_stream_tvalid,
  output logic                  out_stream_tuser
);

  localparam int            XW          = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int            YW          = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_LAST      = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(Y_SIZE - 1);
  localparam logic [XW-1:0] CELL_X_MASK = XW'((1 << CELL_W_LOG2) - 1);
  localparam logic [YW-1:0] CELL_Y_MASK = YW'((1 << CELL_H_LOG2) - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          en, issue, at_origin, x_last, y_last;
  logic          s1_valid, s1_sof, s1_eol, s1_border;
  rgb_t          rgb;

  assign en          = ~out_stream_tvalid | out_stream_tready;
  assign at_origin   = (x == '0) && (y == '0);
  assign x_last      = (x == X_LAST);
  assign y_last      = (y == Y_LAST);
  // run only gates the start of a frame; mid-frame the scan always continues.
  assign issue       = en & (run | ~at_origin);
  assign state_rd_en = issue & aresetn;
  assign state_addr  = AW'(((int'(y) >> CELL_H_LOG2) * GRID_W) + (int'(x) >> CELL_W_LOG2));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      x          <= '0;
      y          <= '0;
      s1_valid   <= 1'b0;
      s1_sof     <= 1'b0;
      s1_eol     <= 1'b0;
      s1_border  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= issue & x_last & y_last;
      if (issue) begin
        x <= x_last ? '0 : x + XW'(1);
        if (x_last) y <= y_last ? '0 : y + YW'(1);
      end
      if (en) begin
        s1_valid  <= issue;
        s1_sof    <= at_origin;
        s1_eol    <= x_last;
        s1_border <= ((x & CELL_X_MASK) == '0) | ((y & CELL_Y_MASK) == '0);
      end
    end
  end

  assign rgb = (grid_en & s1_border) ? GRID_RGB : PALETTE[24*int'(state_data) +: 24];

  assign out_stream_tkeep = TKEEP_ALL;

  rgb_packer_4to3 u_packer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .en       (en),
    .in_valid (s1_valid),
    .in_sof   (s1_sof),
    .in_eol   (s1_eol),
    .in_rgb   (rgb),
    .tdata    (out_stream_tdata),
    .tvalid   (out_stream_tvalid),
    .tlast    (out_stream_tlast),
    .tuser    (out_stream_tuser)
  );

endmodule
